// File: rtl/perm_map_gen.sv
// perm_map_gen: sequential destination-map generator for the lane scatter
// network. It sweeps stage x group and emits one packed destination bus per
// beat on a valid/ready output. A done pulse closes each sweep.
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready.
// While out_valid is high and out_ready is low, dest_bus, out_stage and
// out_grp hold their values. out_valid only falls after a transfer.
//
// Optional feature: define PERM_MAP_INV_EN to add the src_bus output. It is
// the inverse map (gather select bus) and is registered alongside dest_bus.
module perm_map_gen #(
    parameter int N    = 8,
    parameter int SELW = 3,
    parameter int STW  = 4,
    parameter int GW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [STW-1:0]    num_stages,
    input  logic [GW-1:0]     num_groups,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*SELW-1:0] dest_bus,
    output logic [STW-1:0]    out_stage,
    output logic [GW-1:0]     out_grp,
    output logic              done
`ifdef PERM_MAP_INV_EN
    ,
    output logic [N*SELW-1:0] src_bus
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]     state;
    logic [STW-1:0] nst_q;
    logic [GW-1:0]  ngr_q;
    logic           last_grp;
    logic           last_beat;
    logic           load_first;
    logic           advance;
    logic [STW-1:0] stage_nxt;
    logic [GW-1:0]  grp_nxt;

    // dest[j] = rotl(j, s mod SELW) + g, all truncated to SELW bits
    function automatic logic [N*SELW-1:0] map_dest(input logic [STW-1:0] s,
                                                   input logic [SELW-1:0] g);
        logic [N*SELW-1:0] bus;
        logic [SELW-1:0]   rot;
        int                r;
        bus = '0;
        r   = int'(s) % SELW;
        for (int j = 0; j < N; j++) begin
            rot = SELW'(j);
            for (int i = 0; i < SELW; i++) begin
                if (i < r) rot = {rot[SELW-2:0], rot[SELW-1]};
            end
            bus[j*SELW +: SELW] = rot + g;
        end
        return bus;
    endfunction

`ifdef PERM_MAP_INV_EN
    // src[k] = rotr(k - g, s mod SELW), so src[dest[j]] == j
    function automatic logic [N*SELW-1:0] map_src(input logic [STW-1:0] s,
                                                  input logic [SELW-1:0] g);
        logic [N*SELW-1:0] bus;
        logic [SELW-1:0]   rot;
        int                r;
        bus = '0;
        r   = int'(s) % SELW;
        for (int k = 0; k < N; k++) begin
            rot = SELW'(k) - g;
            for (int i = 0; i < SELW; i++) begin
                if (i < r) rot = {rot[0], rot[SELW-1:1]};
            end
            bus[k*SELW +: SELW] = rot;
        end
        return bus;
    endfunction
`endif

    // Status outputs are pure decodes of the registered state
    assign busy      = (state != IDLE);
    assign out_valid = (state == RUN);
    assign done      = (state == FIN);

    // Beat sequencing: next (stage, grp) and last-beat detection
    always_comb begin
        last_grp   = (out_grp == ngr_q - GW'(1));
        last_beat  = last_grp && (out_stage == nst_q - STW'(1));
        stage_nxt  = last_grp ? out_stage + STW'(1) : out_stage;
        grp_nxt    = last_grp ? '0 : out_grp + GW'(1);
        load_first = (state == IDLE) && start &&
                     (num_stages != '0) && (num_groups != '0);
        advance    = (state == RUN) && out_ready && !last_beat;
    end

    // Control FSM and latched sweep dimensions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            nst_q <= '0;
            ngr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        nst_q <= num_stages;
                        ngr_q <= num_groups;
                        state <= load_first ? RUN : FIN;
                    end
                end
                RUN: begin
                    if (out_ready && last_beat) state <= FIN;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Beat registers: load beat (0,0) on start, step on each non-final transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_stage <= '0;
            out_grp   <= '0;
            dest_bus  <= '0;
`ifdef PERM_MAP_INV_EN
            src_bus   <= '0;
`endif
        end else if (load_first) begin
            out_stage <= '0;
            out_grp   <= '0;
            dest_bus  <= map_dest('0, '0);
`ifdef PERM_MAP_INV_EN
            src_bus   <= map_src('0, '0);
`endif
        end else if (advance) begin
            out_stage <= stage_nxt;
            out_grp   <= grp_nxt;
            dest_bus  <= map_dest(stage_nxt, grp_nxt[SELW-1:0]);
`ifdef PERM_MAP_INV_EN
            src_bus   <= map_src(stage_nxt, grp_nxt[SELW-1:0]);
`endif
        end
    end

endmodule

// File: tb/tb_perm_map_gen.sv
// tb_perm_map_gen: directed bench for perm_map_gen (N=8, SELW=3).
// Stimulus pushes expected beats {stage, grp, dest} into exp_q; a monitor
// pops and compares on every transfer. Directed checks cover timing of
// busy/done, stalls, zero-count starts and mid-sweep reset.
module tb_perm_map_gen;

    localparam int N    = 8;
    localparam int SELW = 3;
    localparam int STW  = 4;
    localparam int GW   = 16;
    localparam int W    = STW + GW + N*SELW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start = 1'b0;
    logic [STW-1:0]    num_stages = '0;
    logic [GW-1:0]     num_groups = '0;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [N*SELW-1:0] dest_bus;
    logic [STW-1:0]    out_stage;
    logic [GW-1:0]     out_grp;
    logic              done;
`ifdef PERM_MAP_INV_EN
    logic [N*SELW-1:0] src_bus;
`endif

    logic [W-1:0] exp_q[$];
    int n_pass     = 0;
    int n_total    = 0;
    int beats_seen = 0;

    perm_map_gen #(.N(N), .SELW(SELW), .STW(STW), .GW(GW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_stages (num_stages),
        .num_groups (num_groups),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dest_bus   (dest_bus),
        .out_stage  (out_stage),
        .out_grp    (out_grp),
        .done       (done)
`ifdef PERM_MAP_INV_EN
        ,
        .src_bus    (src_bus)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Reference map from the arithmetic definition
    function automatic logic [N*SELW-1:0] model_dest(int s, int g);
        logic [N*SELW-1:0] bus;
        int r;
        int rot;
        bus = '0;
        r   = s % SELW;
        for (int j = 0; j < N; j++) begin
            rot = ((j << r) | (j >> (SELW - r))) % N;
            bus[j*SELW +: SELW] = SELW'((rot + g) % N);
        end
        return bus;
    endfunction

    task automatic push_sweep(input int ns, input int ng, input int limit);
        int cnt;
        cnt = 0;
        for (int s = 0; s < ns; s++)
            for (int g = 0; g < ng; g++) begin
                if (cnt < limit)
                    exp_q.push_back({STW'(s), GW'(g), model_dest(s, g)});
                cnt++;
            end
    endtask

    // Driver: start accepted at the second edge; returns 1ns into cycle k+1
    task automatic do_start(input int ns, input int ng);
        @(posedge clk);
        #1;
        start      = 1'b1;
        num_stages = STW'(ns);
        num_groups = GW'(ng);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int cnt;
        cnt = 0;
        while (done !== 1'b1 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        check("done_pulse", done, 1);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {out_stage, out_grp}, 0);
            end else begin
                check("beat", {out_stage, out_grp, dest_bus}, exp_q.pop_front());
            end
`ifdef PERM_MAP_INV_EN
            begin
                logic ok;
                int d;
                ok = 1'b1;
                for (int j = 0; j < N; j++) begin
                    d = int'(dest_bus[j*SELW +: SELW]);
                    if (src_bus[d*SELW +: SELW] != SELW'(j)) ok = 1'b0;
                end
                check("inverse_relation", ok, 1);
                if (out_stage == 1 && out_grp == 2)
                    check("src5_s1_g2", src_bus[5*SELW +: SELW], 5);
            end
`endif
        end
    end

    // Directed sequence
    initial begin
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_dest", dest_bus, 0);
        check("rst_stage", out_stage, 0);
        check("rst_grp", out_grp, 0);
`ifdef PERM_MAP_INV_EN
        check("rst_src", src_bus, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // 1x1 sweep: identity beat, done two cycles after start
        push_sweep(1, 1, 99);
        do_start(1, 1);
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_valid", out_valid, 1);
        check("t1_dest_identity", dest_bus, 24'o76543210);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_valid_low", out_valid, 0);
        @(negedge clk);
        check("t1_idle_busy", busy, 0);
        check("t1_done_low", done, 0);

        // 2x3 sweep with ready high: spot values and total length
        push_sweep(2, 3, 99);
        do_start(2, 3);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("t2_s1g0_pos", {out_stage, out_grp}, {4'd1, 16'd0});
        check("t2_s1g0_dest", dest_bus, 24'o75316420);
        repeat (2) @(negedge clk);
        check("t2_s1g2_pos", {out_stage, out_grp}, {4'd1, 16'd2});
        check("t2_s1g2_dest", dest_bus, 24'o17530642);
        @(negedge clk);
        check("t2_done", done, 1);
        @(negedge clk);
        check("t2_idle", busy, 0);

        // 2x3 sweep, ready low for three cycles on beat (0,1)
        begin
            int b0;
            push_sweep(2, 3, 99);
            b0 = beats_seen;
            do_start(2, 3);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("t3_stall_valid", out_valid, 1);
                check("t3_stall_pos", {out_stage, out_grp}, {4'd0, 16'd1});
                check("t3_stall_dest", dest_bus, 24'o07654321);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            wait_done(20);
            check("t3_beat_count", beats_seen - b0, 6);
            @(negedge clk);
            check("t3_idle", busy, 0);
        end

        // Zero group count: no beats, done next cycle, start in FIN ignored
        do_start(3, 0);
        start      = 1'b1;
        num_stages = 4'd1;
        num_groups = 16'd1;
        @(negedge clk);
        check("t4_done", done, 1);
        check("t4_busy", busy, 1);
        check("t4_no_valid", out_valid, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("t4_idle_busy", busy, 0);
        check("t4_done_low", done, 0);
        @(negedge clk);
        check("t4_start_ignored", {busy, out_valid}, 0);

        // Reset asserted during beat (1,1) of a 2x3 sweep
        push_sweep(2, 3, 5);
        do_start(2, 3);
        @(negedge clk);
        repeat (4) @(negedge clk);
        check("t5_pos_before_rst", {out_stage, out_grp}, {4'd1, 16'd1});
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_outputs",
              {busy, out_valid, done, out_stage, out_grp, dest_bus}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_done", done, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_after_release", {busy, done, out_valid}, 0);
        push_sweep(1, 2, 99);
        do_start(1, 2);
        @(negedge clk);
        check("t5_restart_pos", {out_stage, out_grp}, 0);
        wait_done(10);

        // 3x4 sweep exercising rotation by 2
        push_sweep(3, 4, 99);
        do_start(3, 4);
        wait_done(40);

        @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
